// File: rtl/jts16_scr_rom_slot_pkg.sv
// Shared types and constants for the scroll-layer ROM slot.
// The watchdog timeout constant is only used when JTS16_SLOT_TIMEOUT_EN is defined.
package jts16_slot_pkg;

  localparam int         SDRAM_AW = 22;
  localparam logic [7:0] SLOT_TMO = 8'hff;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } slot_st_t;

  typedef enum logic {
    PORT_MAP,
    PORT_SCR
  } slot_port_t;

endpackage

// File: rtl/jts16_scr_rom_slot_if.sv
// Bus bundle between the scroll layer, the ROM slot and the SDRAM controller.
// The slot uses the slave modport; the master modport drives it.
interface jts16_scr_rom_slot_if;
  import jts16_slot_pkg::*;

  logic [14:0]         map_addr;
  logic                map_ok;
  logic [15:0]         map_data;
  logic [16:0]         scr_addr;
  logic                scr_ok;
  logic [31:0]         scr_data;
  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                sdram_rdy;
  logic [31:0]         sdram_din;

  modport slave (
    input  map_addr, scr_addr, sdram_ack, sdram_rdy, sdram_din,
    output map_ok, map_data, scr_ok, scr_data, sdram_req, sdram_addr
  );

  modport master (
    output map_addr, scr_addr, sdram_ack, sdram_rdy, sdram_din,
    input  map_ok, map_data, scr_ok, scr_data, sdram_req, sdram_addr
  );

endinterface

// File: rtl/jts16_scr_rom_slot_port.sv
// One client port latch: fetched address, 32-bit data and valid bit.
// ok is a combinational compare so it drops in the same cycle the address moves.
module jts16_slot_port
  import jts16_slot_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_addr,
  input  logic          i_load,
  input  logic [AW-1:0] i_fa,
  input  logic [31:0]   i_din,
  output logic          o_ok,
  output logic [31:0]   o_fd
);

  logic [AW-1:0] r_fa;
  logic [31:0]   r_fd;
  logic          r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fa    <= '0;
      r_fd    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_fa    <= i_fa;
      r_fd    <= i_din;
      r_valid <= 1'b1;
    end
  end

  assign o_ok = r_valid && (i_addr == r_fa);
  assign o_fd = r_fd;

endmodule

// File: rtl/jts16_scr_rom_slot.sv
// Serves the scroll layer's map and pattern ROM ports from SDRAM with a round-robin arbiter.
// Optional JTS16_SLOT_TIMEOUT_EN adds a WAIT_RDY watchdog that aborts stuck reads.
module jts16_scr_rom_slot
  import jts16_slot_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] MAP_OFFSET = 22'h0,
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET = 22'h0
) (
  input logic                  clk,
  input logic                  rst,
  jts16_scr_rom_slot_if.slave  bus
);

  slot_st_t            r_state, w_nextState;
  slot_port_t          r_sel, w_issuePort;
  logic [SDRAM_AW-1:0] r_addr;
  logic [15:0]         r_fa;

  logic                w_issue, w_done, w_tmoHit;
  logic                w_mapLoad, w_scrLoad;
  logic                w_mapOk, w_scrOk, w_mapPend, w_scrPend;
  logic [31:0]         w_mapFd, w_scrFd;
  logic [SDRAM_AW-1:0] w_mapSdAddr, w_scrSdAddr;
  logic                w_unused;

  assign w_mapSdAddr = MAP_OFFSET + {7'd0, bus.map_addr[14:1], 1'b0};
  assign w_scrSdAddr = SCR_OFFSET + {5'd0, bus.scr_addr[16:1], 1'b0};
  assign w_unused    = bus.scr_addr[0];

  assign w_done    = bus.sdram_rdy &&
                     ((r_state == WAIT_RDY) || ((r_state == WAIT_ACK) && bus.sdram_ack));
  assign w_mapLoad = w_done && (r_sel == PORT_MAP);
  assign w_scrLoad = w_done && (r_sel == PORT_SCR);

  jts16_slot_port #(.AW(14)) u_map (
    .clk    (clk),
    .rst    (rst),
    .i_addr (bus.map_addr[14:1]),
    .i_load (w_mapLoad),
    .i_fa   (r_fa[13:0]),
    .i_din  (bus.sdram_din),
    .o_ok   (w_mapOk),
    .o_fd   (w_mapFd)
  );

  jts16_slot_port #(.AW(16)) u_scr (
    .clk    (clk),
    .rst    (rst),
    .i_addr (bus.scr_addr[16:1]),
    .i_load (w_scrLoad),
    .i_fa   (r_fa),
    .i_din  (bus.sdram_din),
    .o_ok   (w_scrOk),
    .o_fd   (w_scrFd)
  );

  // On the completing cycle, look ahead at the port being filled so the next grant can chain at once
  assign w_mapPend = w_mapLoad ? (bus.map_addr[14:1] != r_fa[13:0]) : !w_mapOk;
  assign w_scrPend = w_scrLoad ? (bus.scr_addr[16:1] != r_fa)       : !w_scrOk;

  // r_sel doubles as the last-served port for round-robin
  always_comb begin
    w_issuePort = PORT_MAP;
    if (w_mapPend && w_scrPend)
      w_issuePort = (r_sel == PORT_MAP) ? PORT_SCR : PORT_MAP;
    else if (w_scrPend)
      w_issuePort = PORT_SCR;
  end

`ifdef JTS16_SLOT_TIMEOUT_EN
  logic [7:0] r_tmo;

  always_ff @(posedge clk) begin
    if (rst)
      r_tmo <= 8'd0;
    else if ((r_state == WAIT_RDY) && (w_nextState == WAIT_RDY))
      r_tmo <= r_tmo + 8'd1;
    else
      r_tmo <= 8'd0;
  end

  assign w_tmoHit = (r_state == WAIT_RDY) && (r_tmo == SLOT_TMO - 8'd1);
`else
  assign w_tmoHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= PORT_MAP;
      r_addr  <= '0;
      r_fa    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_issue) begin
        r_sel <= w_issuePort;
        if (w_issuePort == PORT_MAP) begin
          r_addr <= w_mapSdAddr;
          r_fa   <= {2'b00, bus.map_addr[14:1]};
        end else begin
          r_addr <= w_scrSdAddr;
          r_fa   <= bus.scr_addr[16:1];
        end
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE:     ;
      WAIT_ACK: if (bus.sdram_ack && !bus.sdram_rdy) w_nextState = WAIT_RDY;
      WAIT_RDY: if (w_tmoHit && !bus.sdram_rdy)      w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
    if ((r_state == IDLE) || w_done) begin
      w_issue     = w_mapPend || w_scrPend;
      w_nextState = (w_mapPend || w_scrPend) ? WAIT_ACK : IDLE;
    end
  end

  always_comb begin
    bus.sdram_req  = (r_state == WAIT_ACK);
    bus.sdram_addr = r_addr;
    bus.map_ok     = w_mapOk;
    bus.map_data   = bus.map_addr[0] ? w_mapFd[31:16] : w_mapFd[15:0];
    bus.scr_ok     = w_scrOk;
    bus.scr_data   = w_scrFd;
  end

endmodule

// File: doc/jts16_scr_rom_slot.md
# jts16_scr_rom_slot

Memory-side responder for the scroll tilemap layer's two ROM fetch ports: the tile map port (15-bit word address, 16-bit data) and the tile pattern port (17-bit word address, 32-bit data). It turns address changes on either port into 32-bit SDRAM read requests, latches the returned data, and raises the matching `*_ok` strobe. It sits between the scroll layer and the SDRAM controller.

## Interface

Parameters:
- `MAP_OFFSET`, 22'h0: SDRAM word base of the map region.
- `SCR_OFFSET`, 22'h0: SDRAM word base of the pattern region.

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `map_addr` in 15: map word address.
- `map_ok` out 1: `map_data` valid for the current `map_addr`.
- `map_data` out 16: map word.
- `scr_addr` in 17: pattern word address; bit 0 is always 0 from the client.
- `scr_ok` out 1: `scr_data` valid for the current `scr_addr`.
- `scr_data` out 32: four-pixel pattern data.
- `sdram_req` out 1: read request, held until `sdram_ack`.
- `sdram_addr` out 22: SDRAM word address.
- `sdram_ack` in 1: request accepted.
- `sdram_rdy` in 1: read data valid, one cycle.
- `sdram_din` in 32: read data.

## Operation

Per-port latch:
- Registers: fetched address `fa`, data `fd`, and `valid`.
- Map `fa` holds `map_addr[14:1]`, giving 32-bit granularity. Pattern `fa` holds `scr_addr[16:1]`.
- `ok = valid && (addr upper bits == fa)`. This is a combinational compare, so `ok` drops in the same cycle the address changes.
- `map_data = map_addr[0] ? fd[31:16] : fd[15:0]`. Both halves hit without a new fetch.
- A port is pending when `!ok`.

SDRAM addresses:
- Map: `MAP_OFFSET + {7'd0, map_addr[14:1], 1'b0}`.
- Pattern: `SCR_OFFSET + {5'd0, scr_addr[16:1], 1'b0}`.
- Sums are 22-bit and wrap modulo 2^22.

Arbiter FSM:
- IDLE:
  - If any port is pending, select it, register the address and port id, assert `sdram_req`, and go to WAIT_ACK.
  - If both ports are pending, grant the one not served last (round-robin; after reset, pattern port first).
- WAIT_ACK: on `sdram_ack`, deassert `sdram_req` and go to WAIT_RDY.
- WAIT_RDY: on `sdram_rdy`, write `sdram_din` into the selected port's `fd`, set `fa` to the registered fetch address, set `valid=1`, and go to IDLE.

Boundary conditions:
- **Address change mid-fetch:** the returning data is still written against the old registered fetch address. `ok` therefore stays low for the new address, the port stays pending, and it is refetched.
- **`sdram_rdy` outside WAIT_RDY:** ignored.
- **`sdram_ack` and `sdram_rdy` in the same cycle:** treated as ack, then rdy. The FSM goes IDLE directly and the data is latched.
- **Reset mid-fetch:** FSM returns to IDLE and both `valid` bits clear. A late `sdram_rdy` is ignored.

## Timing

Reset values:
- `sdram_req=0`, `sdram_addr=0`.
- `map_ok=0`, `scr_ok=0`.
- `map_data=0`, `scr_data=0`.
- FSM in IDLE.

Latency:
- Address change at cycle N: `sdram_req` is high from N+1.
- `sdram_rdy` at cycle R: `ok` is high at R+1, if the address is unchanged.
- Minimum miss latency: 3 cycles plus SDRAM latency.
- Hit, including the other map half: 0 cycles.

Handshake rules:
- `sdram_addr` is stable while `sdram_req` is high.
- At most one request is outstanding.
- Back-to-back: after `sdram_rdy` at R, the next `sdram_req` can rise at R+1.

## Configuration

`JTS16_SLOT_TIMEOUT_EN`:
- Defined: an 8-bit watchdog counts cycles in WAIT_RDY. At 255 it aborts to IDLE without setting `valid`, and the port re-requests.
- Undefined: WAIT_RDY waits indefinitely.

## Structure

- Package `jts16_slot_pkg` holds:
  - the state enum `slot_st_t` (IDLE, WAIT_ACK, WAIT_RDY);
  - `SDRAM_AW=22`;
  - the timeout constant `SLOT_TMO=8'hff`.
- Sub-module `jts16_slot_port`, parameterised by address width, holds `fa`/`fd`/`valid` and the compare. It is instantiated once for the map port and once for the pattern port.

## Test plan

- **Cold miss:** reset, then `scr_addr=17'h00010`, ack after 2 cycles, rdy with `32'hDEADBEEF` after 5 → `sdram_addr=SCR_OFFSET+22'h10`; `scr_ok` high the cycle after rdy; `scr_data=32'hDEADBEEF`.
- **Map half hit:** serve `map_addr=15'h0100` with `32'h1234ABCD`, then set `map_addr=15'h0101` → no new `sdram_req`; `map_data` goes `16'hABCD` then `16'h1234`; `map_ok` stays high.
- **Contention:** both ports miss in the same cycle after reset → pattern is served first, map second; alternation holds over 4 consecutive double misses.
- **Mid-fetch change:** change `scr_addr` from `17'h20` to `17'h40` while in WAIT_RDY → `scr_ok` stays low after rdy; a second request at `SCR_OFFSET+22'h40` follows; `ok` rises after its rdy.
- **Reset during WAIT_RDY:** assert `rst` while in WAIT_RDY, then pulse `sdram_rdy` → both `ok` low, `sdram_req` low, data not latched.
- **Timeout (with `JTS16_SLOT_TIMEOUT_EN`):** ack but never rdy → return to IDLE after 255 cycles in WAIT_RDY, followed by a re-request to the same address.
